// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift-register serializer: register mode codes and
// controller state encoding.
package shift_ctrl_pkg;

   typedef enum logic [1:0] {
      SR_CLEAR = 2'b00,
      SR_LOAD  = 2'b01,
      SR_SHL   = 2'b10,
      SR_SHR   = 2'b11
   } sr_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } ctrl_state_e;

endpackage

// File: rtl/shift_reg.sv
// Mode-controlled shift register: clear, parallel load, shift left or right.
// It has no hold code, so whoever drives mode_i owns it every cycle.
module shift_reg
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] q_o
);

   // Shifts always bring in zeros, so a fully shifted word leaves the register empty.
   always_ff @(posedge clk) begin
      case (sr_mode_e'(mode_i))
         SR_CLEAR: q_o <= '0;
         SR_LOAD:  q_o <= data_i;
         SR_SHL:   q_o <= {q_o[WIDTH-2:0], 1'b0};
         SR_SHR:   q_o <= {1'b0, q_o[WIDTH-1:1]};
         default:  q_o <= '0;
      endcase
   end

endmodule

// File: rtl/shift_serializer_top.sv
// Controller wired to the shift register it sequences; the register contents
// are exposed for observation.
module shift_serializer_top
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] data_in,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             done,
   output logic [WIDTH-1:0] reg_q
);

   logic [1:0]       srMode;
   logic [WIDTH-1:0] srData;

   shift_serializer_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .dir          (dir),
      .data_in      (data_in),
      .abort        (abort),
      .sr_q         (reg_q),
      .sr_mode      (srMode),
      .sr_data      (srData),
      .ready        (ready),
      .busy         (busy),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .done         (done)
   );

   shift_reg #(.WIDTH(WIDTH)) u_reg (
      .clk    (clk),
      .mode_i (srMode),
      .data_i (srData),
      .q_o    (reg_q)
   );

endmodule

// File: rtl/shift_serializer_ctrl.sv
// Sequencer that loads a parallel word into the shift register and shifts it
// out one bit per cycle, MSB-first or LSB-first, with a valid strobe.
module shift_serializer_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] data_in,
   input  logic             abort,
   input  logic [WIDTH-1:0] sr_q,
   output logic [1:0]       sr_mode,
   output logic [WIDTH-1:0] sr_data,
   output logic             ready,
   output logic             busy,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   ctrl_state_e      state_q;
   logic [WIDTH-1:0] word_q;
   logic             dir_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sr_q_unused;

   // Only the end bit facing the shift direction is observed.
   assign sr_q_unused = ^sr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  word_q  <= data_in;
                  dir_q   <= dir;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               cnt_q   <= '0;
               state_q <= abort ? IDLE : SHIFT;
            end
            SHIFT: begin
               if (abort) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Reset overrides the decode so the register clears on the same edge as the controller.
   always_comb begin
      sr_mode      = SR_CLEAR;
      sr_data      = '0;
      ready        = 1'b0;
      busy         = 1'b0;
      serial_out   = 1'b0;
      serial_valid = 1'b0;
      done         = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               ready = 1'b1;
            end
            LOAD: begin
               sr_mode = SR_LOAD;
               sr_data = word_q;
               busy    = 1'b1;
            end
            SHIFT: begin
               sr_mode      = dir_q ? SR_SHR : SR_SHL;
               busy         = 1'b1;
               serial_valid = 1'b1;
               serial_out   = dir_q ? sr_q[0] : sr_q[WIDTH-1];
            end
            DONE: begin
               done = 1'b1;
            end
            default: begin
               sr_mode = SR_CLEAR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_serializer_ctrl.sv
// Directed bench for the serializer controller closed around a shift register,
// with a scoreboard of expected serial bits.
module tb_shift_serializer_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             dir = 1'b0;
   logic             abort = 1'b0;
   logic [WIDTH-1:0] dataIn = '0;

   logic [1:0]       srMode;
   logic [WIDTH-1:0] srData;
   logic [WIDTH-1:0] srQ;
   logic             ready, busy, serialOut, serialValid, done;

   logic             topReady, topBusy, topSerialOut, topSerialValid, topDone;
   logic [WIDTH-1:0] topRegQ;

   int assertCount = 0;
   int failCount = 0;
   int doneCount = 0;
   int doneBase = 0;
   bit expQ[$];
   bit expBit;

   always #5 clk = ~clk;

   shift_serializer_ctrl #(.WIDTH(WIDTH)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .dir          (dir),
      .data_in      (dataIn),
      .abort        (abort),
      .sr_q         (srQ),
      .sr_mode      (srMode),
      .sr_data      (srData),
      .ready        (ready),
      .busy         (busy),
      .serial_out   (serialOut),
      .serial_valid (serialValid),
      .done         (done)
   );

   shift_reg #(.WIDTH(WIDTH)) u_reg (
      .clk    (clk),
      .mode_i (srMode),
      .data_i (srData),
      .q_o    (srQ)
   );

   shift_serializer_top #(.WIDTH(WIDTH)) u_top (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .dir          (dir),
      .data_in      (dataIn),
      .abort        (abort),
      .ready        (topReady),
      .busy         (topBusy),
      .serial_out   (topSerialOut),
      .serial_valid (topSerialValid),
      .done         (topDone),
      .reg_q        (topRegQ)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sampleNow();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] d, input logic dr,
                                input logic ab, input logic r);
      start  = s;
      dataIn = d;
      dir    = dr;
      abort  = ab;
      rst    = r;
   endtask

   task automatic pushBits(input logic [WIDTH-1:0] d, input logic dr, input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back(dr ? d[i] : d[WIDTH-1-i]);
      end
   endtask

   task automatic acceptWord(input logic [WIDTH-1:0] d, input logic dr);
      nextCycle();
      applyStimulus(1'b1, d, dr, 1'b0, 1'b0);
      sampleNow();
      checkOutput("acceptReady", ready, 1);
      checkOutput("acceptTopReady", topReady, 1);
      checkOutput("idleMode", srMode, 2'b00);
   endtask

   task automatic loadCycle(input logic [WIDTH-1:0] d);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      sampleNow();
      checkOutput("loadMode", srMode, 2'b01);
      checkOutput("loadData", srData, d);
      checkOutput("loadBusy", busy, 1);
      checkOutput("loadTopBusy", topBusy, 1);
      checkOutput("loadReady", ready, 0);
   endtask

   task automatic shiftCycles(input logic dr, input int n);
      for (int i = 0; i < n; i++) begin
         nextCycle();
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
         sampleNow();
         checkOutput("shiftMode", srMode, dr ? 2'b11 : 2'b10);
         checkOutput("shiftValid", serialValid, 1);
         checkOutput("shiftBusy", busy, 1);
         checkOutput("shiftData", srData, 0);
      end
   endtask

   task automatic doneCycle(input logic s, input logic [WIDTH-1:0] d);
      nextCycle();
      applyStimulus(s, d, 1'b0, 1'b0, 1'b0);
      sampleNow();
      checkOutput("donePulse", done, 1);
      checkOutput("doneTopPulse", topDone, 1);
      checkOutput("doneMode", srMode, 2'b00);
      checkOutput("doneReady", ready, 0);
      checkOutput("doneBusy", busy, 0);
      checkOutput("doneRegEmpty", srQ, 0);
      checkOutput("doneTopRegEmpty", topRegQ, 0);
   endtask

   task automatic idleCycle();
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      sampleNow();
      checkOutput("idleReady", ready, 1);
      checkOutput("idleDone", done, 0);
      checkOutput("idleBusy", busy, 0);
   endtask

   // Scoreboard: every valid bit must match the next expected bit, and the
   // serial output must be quiet whenever the strobe is low.
   always @(negedge clk) begin
      if (serialValid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedBit", serialValid, 0);
         end else begin
            expBit = expQ.pop_front();
            checkOutput("serialBit", serialOut, expBit);
            checkOutput("topSerialBit", topSerialOut & topSerialValid, expBit);
         end
      end else begin
         checkOutput("serialIdleZero", serialOut, 0);
         checkOutput("topValidIdle", topSerialValid, 0);
      end
      if (done) doneCount++;
   end

   initial begin
      logic [WIDTH-1:0] d;
      logic             dr;

      // Reset: outputs forced quiet, start ignored while reset is held.
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      sampleNow();
      checkOutput("rstMode", srMode, 2'b00);
      checkOutput("rstReady", ready, 0);
      checkOutput("rstValid", serialValid, 0);
      checkOutput("rstData", srData, 0);
      nextCycle();
      applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
      sampleNow();
      checkOutput("rstStartIgnored", ready, 0);
      checkOutput("rstBusy", busy, 0);
      idleCycle();
      checkOutput("rstRegClear", srQ, 0);

      // 0x1E MSB-first.
      doneBase = doneCount;
      acceptWord(8'h1E, 1'b0);
      pushBits(8'h1E, 1'b0, WIDTH);
      loadCycle(8'h1E);
      shiftCycles(1'b0, WIDTH);
      doneCycle(1'b0, '0);
      idleCycle();
      checkOutput("msbDoneCount", doneCount - doneBase, 1);

      // 0x1E LSB-first.
      doneBase = doneCount;
      acceptWord(8'h1E, 1'b1);
      pushBits(8'h1E, 1'b1, WIDTH);
      loadCycle(8'h1E);
      shiftCycles(1'b1, WIDTH);
      doneCycle(1'b0, '0);
      idleCycle();
      checkOutput("lsbDoneCount", doneCount - doneBase, 1);

      // start held high with data changing every cycle: accepts every WIDTH+3 cycles.
      doneBase = doneCount;
      for (int k = 0; k < 3 * (WIDTH + 3); k++) begin
         nextCycle();
         d  = WIDTH'($urandom);
         dr = 1'($urandom);
         applyStimulus(1'b1, d, dr, 1'b0, 1'b0);
         sampleNow();
         checkOutput("holdReady", ready, (k % (WIDTH + 3)) == 0);
         if ((k % (WIDTH + 3)) == 0) pushBits(d, dr, WIDTH);
      end
      idleCycle();
      checkOutput("holdDrained", expQ.size(), 0);
      checkOutput("holdDoneCount", doneCount - doneBase, 3);

      // Abort on the 4th bit of 0xFF: four ones, no done, register cleared.
      doneBase = doneCount;
      acceptWord(8'hFF, 1'b0);
      pushBits(8'hFF, 1'b0, 4);
      loadCycle(8'hFF);
      shiftCycles(1'b0, 3);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      sampleNow();
      checkOutput("abortCycleValid", serialValid, 1);
      checkOutput("abortCycleMode", srMode, 2'b10);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      sampleNow();
      checkOutput("abortIdleReady", ready, 1);
      checkOutput("abortIdleMode", srMode, 2'b00);
      checkOutput("abortNoDone", done, 0);
      idleCycle();
      checkOutput("abortRegClear", srQ, 0);
      checkOutput("abortDoneCount", doneCount - doneBase, 0);
      checkOutput("abortDrained", expQ.size(), 0);

      // Reset in the middle of an LSB-first word.
      doneBase = doneCount;
      acceptWord(8'hA5, 1'b1);
      pushBits(8'hA5, 1'b1, 3);
      loadCycle(8'hA5);
      shiftCycles(1'b1, 3);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      sampleNow();
      checkOutput("midRstMode", srMode, 2'b00);
      checkOutput("midRstValid", serialValid, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstReady", ready, 0);
      checkOutput("midRstDone", done, 0);
      idleCycle();
      checkOutput("midRstMode2", srMode, 2'b00);
      checkOutput("midRstRegClear", srQ, 0);
      checkOutput("midRstDoneCount", doneCount - doneBase, 0);
      checkOutput("midRstDrained", expQ.size(), 0);

      // start in DONE is ignored; start with abort in the following IDLE wins.
      doneBase = doneCount;
      acceptWord(8'h5A, 1'b0);
      pushBits(8'h5A, 1'b0, WIDTH);
      loadCycle(8'h5A);
      shiftCycles(1'b0, WIDTH);
      doneCycle(1'b1, 8'h3C);
      nextCycle();
      applyStimulus(1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
      sampleNow();
      checkOutput("afterDoneReady", ready, 1);
      pushBits(8'h81, 1'b0, WIDTH);
      loadCycle(8'h81);
      shiftCycles(1'b0, WIDTH);
      doneCycle(1'b0, '0);
      idleCycle();
      checkOutput("doneStartCount", doneCount - doneBase, 2);
      checkOutput("finalDrained", expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/shift_serializer_ctrl.md
Name: shift_serializer_ctrl

Overview:
Sequencer for the team's 8-bit mode-controlled shift register (mode 00=clear, 01=load, 10=shift left, 11=shift right).
- Accepts a parallel word through a valid/ready handshake.
- Drives the register's mode and load-data pins to load the word, then shift it out one bit per cycle, MSB-first or LSB-first.
- Presents each bit on a serial output with a valid strobe.
- The register has no hold code, so this block owns its mode pins every cycle.

Parameters:
WIDTH, 8, register width and number of shift cycles per word.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request to serialize data_in; accepted when start && ready
dir  input  1  0 = shift left (MSB-first), 1 = shift right (LSB-first); captured with start
data_in  input  WIDTH  word to serialize; captured with start
abort  input  1  cancel an in-flight word
sr_q  input  WIDTH  shift-register output, fed back
sr_mode  output  2  mode pins to the shift register
sr_data  output  WIDTH  parallel-load data to the shift register
ready  output  1  high only in IDLE
busy  output  1  high in LOAD and SHIFT
serial_out  output  1  current serial bit
serial_valid  output  1  serial_out is valid this cycle
done  output  1  one-cycle pulse after the last bit

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. Registers: state, word_q (WIDTH), dir_q, cnt ($clog2(WIDTH+1) bits).
- Reset:
  - state=IDLE, cnt=0, word_q=0, dir_q=0.
  - While rst=1, sr_mode is forced combinationally to 00, so the register clears on the same edge.
  - While rst=1: ready=0, busy=0, serial_valid=0, done=0, serial_out=0, sr_data=0.
- IDLE:
  - sr_mode=00 (register held at zero); ready=1.
  - On start: capture data_in into word_q and dir into dir_q; next state LOAD.
- LOAD:
  - sr_mode=01, sr_data=word_q, busy=1.
  - Next state SHIFT with cnt=0.
- SHIFT:
  - sr_mode = dir_q ? 11 : 10; busy=1; serial_valid=1.
  - serial_out = dir_q ? sr_q[0] : sr_q[WIDTH-1], sampled before the shift edge.
  - cnt increments each cycle. When cnt==WIDTH-1, next state is DONE.
- DONE:
  - sr_mode=00, done=1, busy=0, ready=0.
  - Next state IDLE.
- Latency, start accepted at edge-cycle T:
  - T+1: LOAD.
  - T+2..T+WIDTH+1: bits, exactly WIDTH serial_valid cycles.
  - T+WIDTH+2: done.
  - T+WIDTH+3: ready again.
  - Minimum start-to-start spacing is WIDTH+3 cycles.
- Outputs that are not driven in a state are 0: sr_data=0 outside LOAD; serial_out=0 when serial_valid=0.
- start while ready=0 is ignored, not queued. data_in and dir are sampled only on the accept cycle.
- abort in LOAD or SHIFT:
  - Next state IDLE; the register is cleared by IDLE's sr_mode=00.
  - No done pulse. serial_valid is still 1 in the abort cycle if it occurs in SHIFT.
  - abort in IDLE or DONE has no effect. abort and start in the same IDLE cycle: start wins.
- rst has priority over abort and start in every state.
- Zero-fill: bits shifted in are 0. serial_out never shows stale data because the word is reloaded from word_q.

Decomposition:
- Package shift_ctrl_pkg holds:
  - sr_mode_e enum: SR_CLEAR=2'b00, SR_LOAD=2'b01, SR_SHL=2'b10, SR_SHR=2'b11.
  - ctrl_state_e enum: IDLE, LOAD, SHIFT, DONE.
- No sub-module inside the controller. A thin top, shift_serializer_top, instantiates shift_serializer_ctrl plus the existing shift register, wiring sr_mode/sr_data/sr_q. The bench targets that top.

Test Plan:
- Reset, then start with data_in=8'h1E, dir=0 -> sr_mode sequence 01, then 10 ×8, then 00; serial_out 0,0,0,1,1,1,1,0 on 8 serial_valid cycles; done pulses at T+10; ready returns at T+11.
- data_in=8'h1E, dir=1 -> sr_mode 11 ×8; serial_out 0,1,1,1,1,0,0,0; register output 8'h00 at DONE.
- start=1 held continuously with data_in changing every cycle -> only words sampled in IDLE cycles are sent; accepts are spaced exactly 11 cycles apart; no bit drops.
- abort asserted at the 4th serial_valid cycle of 8'hFF, dir=0 -> exactly 4 ones emitted; no done; next cycle IDLE with sr_mode=00; register 8'h00 one edge later.
- rst asserted mid-SHIFT -> sr_mode=00 in that same cycle; all outputs 0; state IDLE; ready=1 the cycle after rst deasserts.
- start asserted in the DONE cycle -> ignored; start asserted in the following IDLE cycle is accepted.
